// File: rtl/mprjram_arbiter.sv
// mprjram_arbiter: round-robin arbiter that shares the single-port user-project
// BRAM between the Wishbone slave port and the matmul accelerator memory port.
// Only one access is in flight at a time. Reads complete after a fixed BRAM
// latency. Optional build macro MPRJRAM_ARB_STATS_EN adds saturating
// grant and stall counters.
module mprjram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int BRAM_LAT = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              acc_req,
  input  logic [3:0]        acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [31:0]       acc_rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
`ifdef MPRJRAM_ARB_STATS_EN
  output logic [15:0]       stat_wb_cnt,
  output logic [15:0]       stat_acc_cnt,
  output logic [15:0]       stat_stall_cnt,
`endif
  input  logic [31:0]       bram_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  typedef enum logic {OWN_WB, OWN_ACC} owner_t;

  localparam logic [3:0] LAT_INIT = 4'(BRAM_LAT - 1);

  state_t            state_reg, state_next;
  owner_t            last_reg, last_next;    // requester granted most recently
  owner_t            owner_reg, owner_next;  // requester of the access in flight
  logic [3:0]        lat_cnt_reg, lat_cnt_next;

  logic              wb_req, resp_cycle, sel_wb, sel_acc;
  logic              ack_next, gnt_next, rvalid_next, en_next;
  logic [3:0]        we_next;
  logic [31:0]       wb_dat_next, acc_rdata_next, wdata_next;
  logic [ADDR_W-1:0] addr_next;

  // Byte offset and bits above the BRAM window are ignored, so addresses alias.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

  assign wb_req     = wbs_cyc_i & wbs_stb_i;
  // A response pulse occupies a cycle in which no new request is sampled.
  assign resp_cycle = wbs_ack_o | acc_rvalid;

  // Arbitration, access issue and response generation.
  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    owner_next     = owner_reg;
    lat_cnt_next   = lat_cnt_reg;
    sel_wb         = 1'b0;
    sel_acc        = 1'b0;
    ack_next       = 1'b0;
    gnt_next       = 1'b0;
    rvalid_next    = 1'b0;
    en_next        = 1'b0;
    we_next        = 4'd0;
    wb_dat_next    = wbs_dat_o;
    acc_rdata_next = acc_rdata;
    addr_next      = bram_addr;
    wdata_next     = bram_wdata;
    case (state_reg)
      IDLE: begin
        if (!resp_cycle) begin
          // On a tie, the requester that was not served last wins.
          if (wb_req && (!acc_req || last_reg == OWN_ACC)) sel_wb = 1'b1;
          else if (acc_req)                                sel_acc = 1'b1;
        end
        if (sel_wb) begin
          owner_next = OWN_WB;
          last_next  = OWN_WB;
          en_next    = 1'b1;
          addr_next  = wbs_adr_i[ADDR_W+1:2];
          wdata_next = wbs_dat_i;
          if (wbs_we_i) begin
            we_next    = wbs_sel_i;
            state_next = WRITE;
          end else begin
            lat_cnt_next = LAT_INIT;
            state_next   = READ;
          end
        end else if (sel_acc) begin
          owner_next = OWN_ACC;
          last_next  = OWN_ACC;
          en_next    = 1'b1;
          gnt_next   = 1'b1;
          addr_next  = acc_addr;
          wdata_next = acc_wdata;
          if (|acc_we) begin
            we_next    = acc_we;
            state_next = WRITE;
          end else begin
            lat_cnt_next = LAT_INIT;
            state_next   = READ;
          end
        end
      end
      WRITE: begin
        // Accelerator writes already completed with their grant pulse.
        if (owner_reg == OWN_WB && wb_req) ack_next = 1'b1;
        state_next = IDLE;
      end
      READ: begin
        if (lat_cnt_reg == 4'd0) begin
          state_next = IDLE;
          if (owner_reg == OWN_WB) begin
            // A master that abandoned the cycle gets no ack.
            if (wb_req) begin
              ack_next    = 1'b1;
              wb_dat_next = bram_rdata;
            end
          end else begin
            rvalid_next    = 1'b1;
            acc_rdata_next = bram_rdata;
          end
        end else begin
          lat_cnt_next = lat_cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= OWN_ACC;
      owner_reg   <= OWN_WB;
      lat_cnt_reg <= 4'd0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'd0;
      acc_gnt     <= 1'b0;
      acc_rvalid  <= 1'b0;
      acc_rdata   <= 32'd0;
      bram_en     <= 1'b0;
      bram_we     <= 4'd0;
      bram_addr   <= '0;
      bram_wdata  <= 32'd0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      owner_reg   <= owner_next;
      lat_cnt_reg <= lat_cnt_next;
      wbs_ack_o   <= ack_next;
      wbs_dat_o   <= wb_dat_next;
      acc_gnt     <= gnt_next;
      acc_rvalid  <= rvalid_next;
      acc_rdata   <= acc_rdata_next;
      bram_en     <= en_next;
      bram_we     <= we_next;
      bram_addr   <= addr_next;
      bram_wdata  <= wdata_next;
    end
  end

`ifdef MPRJRAM_ARB_STATS_EN
  logic in_service, wb_pend, acc_pend, stall;
  // A requester whose own access is being served is not waiting.
  assign in_service = (state_reg != IDLE) || resp_cycle;
  assign wb_pend    = wb_req && !(in_service && owner_reg == OWN_WB);
  assign acc_pend   = acc_req && !(in_service && owner_reg == OWN_ACC);
  assign stall      = (wb_pend && !sel_wb) || (acc_pend && !sel_acc);

  // Saturating grant and stall counters.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      stat_wb_cnt    <= 16'd0;
      stat_acc_cnt   <= 16'd0;
      stat_stall_cnt <= 16'd0;
    end else begin
      if (sel_wb && stat_wb_cnt != 16'hFFFF)      stat_wb_cnt    <= stat_wb_cnt + 16'd1;
      if (sel_acc && stat_acc_cnt != 16'hFFFF)    stat_acc_cnt   <= stat_acc_cnt + 16'd1;
      if (stall && stat_stall_cnt != 16'hFFFF)    stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mprjram_arbiter.sv
// tb_mprjram_arbiter: randomized scoreboard bench for mprjram_arbiter with a
// behavioural BRAM, a shadow-memory reference model and an event monitor.
module tb_mprjram_arbiter;
  localparam int ADDR_W = 10;
  localparam int LAT    = 10;
  localparam int K_ACK  = 0;
  localparam int K_GNT  = 1;
  localparam int K_RV   = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    bit          chk_data;
    int          at;
  } exp_t;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] dat;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic              wbs_ack_o;
  logic              acc_req, acc_gnt, acc_rvalid;
  logic [3:0]        acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata, acc_rdata;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata, bram_rdata;
`ifdef MPRJRAM_ARB_STATS_EN
  logic [15:0]       stat_wb_cnt, stat_acc_cnt, stat_stall_cnt;
`endif

  mprjram_arbiter #(.ADDR_W(ADDR_W), .BRAM_LAT(LAT)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
`ifdef MPRJRAM_ARB_STATS_EN
    .stat_wb_cnt(stat_wb_cnt), .stat_acc_cnt(stat_acc_cnt), .stat_stall_cnt(stat_stall_cnt),
`endif
    .bram_rdata(bram_rdata)
  );

  // Behavioural BRAM: data for an address issued at edge t is valid at edge t+LAT.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_pipe [0:LAT-2];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bram_en) begin
      rd_pipe[0] <= mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
    end
    for (int k = 1; k < LAT - 1; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bram_rdata = rd_pipe[LAT-2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [31:0] ref_mem [0:1023];
  bit   ref_last_acc;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic int at_of(input int a, input int off);
    return (a < 0) ? -1 : a + off;
  endfunction

  function automatic string kname(input int k);
    return (k == K_ACK) ? "wb_ack" : (k == K_GNT) ? "acc_gnt" : "acc_rvalid";
  endfunction

  // Reference model: serve a WB access granted at edge a; returns next arbitration edge.
  function automatic int model_wb(input op_t o, input int a);
    exp_t e;
    int   w;
    w = int'(o.adr[11:2]);
    e.kind = K_ACK;
    if (o.we) begin
      ref_mem[w] = merge(ref_mem[w], o.dat, o.be);
      e.data = 32'd0; e.chk_data = 1'b0; e.at = at_of(a, 1);
      exp_q.push_back(e);
      return a + 3;
    end
    e.data = ref_mem[w]; e.chk_data = 1'b1; e.at = at_of(a, LAT);
    exp_q.push_back(e);
    return a + LAT + 2;
  endfunction

  // Reference model: serve an accelerator access granted at edge a.
  function automatic int model_acc(input op_t o, input int a);
    exp_t e;
    int   w;
    w = int'(o.adr[9:0]);
    e.kind = K_GNT; e.data = 32'd0; e.chk_data = 1'b0; e.at = at_of(a, 0);
    exp_q.push_back(e);
    if (o.be != 4'd0) begin
      ref_mem[w] = merge(ref_mem[w], o.dat, o.be);
      return a + 2;
    end
    e.kind = K_RV; e.data = ref_mem[w]; e.chk_data = 1'b1; e.at = at_of(a, LAT);
    exp_q.push_back(e);
    return a + LAT + 2;
  endfunction

  // Monitor: pop and compare on every response pulse.
  task automatic check_evt(input int k, input logic [31:0] d);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: cyc %0d event seen, required none", kname(k), cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k) begin
      fails++;
      $display("FAIL order: cyc %0d got %s required %s", cyc, kname(k), kname(e.kind));
    end else if (e.chk_data && d !== e.data) begin
      fails++;
      $display("FAIL %s_data: cyc %0d got %h required %h", kname(k), cyc, d, e.data);
    end else if (e.at >= 0 && cyc != e.at) begin
      fails++;
      $display("FAIL %s_timing: got cycle %0d required %0d", kname(k), cyc, e.at);
    end else begin
      $display("[TB] cyc %0d %s ok data=%h", cyc, kname(k), d);
    end
  endtask

  always @(negedge clk) begin
    if (wbs_ack_o)  check_evt(K_ACK, wbs_dat_o);
    if (acc_gnt)    check_evt(K_GNT, 32'd0);
    if (acc_rvalid) check_evt(K_RV, acc_rdata);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wb_drive(input op_t o);
    int n;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = o.we;
    wbs_sel_i = o.be; wbs_adr_i = o.adr; wbs_dat_i = o.dat;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbs_ack_o && n < 200);
    tests++;
    if (!wbs_ack_o) begin
      fails++;
      $display("FAIL wb_timeout: ack=%0b after %0d cycles, required 1", wbs_ack_o, n);
    end
    step();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic acc_drive(input op_t o);
    int n;
    acc_req = 1'b1; acc_we = o.be; acc_addr = o.adr[9:0]; acc_wdata = o.dat;
    n = 0;
    do begin @(negedge clk); n++; end while (!acc_gnt && n < 200);
    tests++;
    if (!acc_gnt) begin
      fails++;
      $display("FAIL acc_gnt_timeout: gnt=%0b after %0d cycles, required 1", acc_gnt, n);
    end
    step();
    acc_req = 1'b0;
    if (o.be == 4'd0) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!acc_rvalid && n < 200);
      tests++;
      if (!acc_rvalid) begin
        fails++;
        $display("FAIL acc_rvalid_timeout: rvalid=%0b after %0d cycles, required 1", acc_rvalid, n);
      end
      step();
    end
  endtask

  task automatic run_batch(input bit do_wb, input op_t wo, input bit do_acc, input op_t ao);
    int a;
    a = cyc + 1;
    if (do_wb && do_acc) begin
      if (ref_last_acc) begin a = model_wb(wo, a); void'(model_acc(ao, a)); ref_last_acc = 1'b1; end
      else begin a = model_acc(ao, a); void'(model_wb(wo, a)); ref_last_acc = 1'b0; end
    end else if (do_wb) begin
      void'(model_wb(wo, a)); ref_last_acc = 1'b0;
    end else if (do_acc) begin
      void'(model_acc(ao, a)); ref_last_acc = 1'b1;
    end
    fork
      if (do_wb)  wb_drive(wo);
      if (do_acc) acc_drive(ao);
    join
    repeat ($urandom_range(0, 3)) step();
  endtask

  function automatic op_t rand_wb();
    op_t o;
    o.we = 1'($urandom_range(0, 1));
    o.be = 4'($urandom_range(0, 15));
    o.adr = $urandom; o.adr[31:24] = 8'h38;
    o.dat = $urandom;
    return o;
  endfunction

  function automatic op_t rand_acc();
    op_t o;
    o.we = 1'b0;
    o.be = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    o.adr = 32'($urandom_range(0, 1023));
    o.dat = $urandom;
    return o;
  endfunction

  function automatic op_t mk(input bit we, input logic [3:0] be, input logic [31:0] adr,
                             input logic [31:0] dat);
    op_t o;
    o.we = we; o.be = be; o.adr = adr; o.dat = dat;
    return o;
  endfunction

  task automatic check_zero(input string nm);
    logic [113:0] v;
    v = {wbs_ack_o, acc_gnt, acc_rvalid, bram_en, bram_we, wbs_dat_o, acc_rdata, bram_addr, bram_wdata};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL %s: outputs=%h required 0", nm, v);
    end else $display("[TB] %s outputs all zero ok", nm);
  endtask

  // WB master that abandons its cycle after `hold` edges: no ack may follow.
  task automatic wb_abort(input op_t o, input int hold);
    int w;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = o.we;
    wbs_sel_i = o.be; wbs_adr_i = o.adr; wbs_dat_i = o.dat;
    repeat (hold) step();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    if (o.we) begin
      w = int'(o.adr[11:2]);
      ref_mem[w] = merge(ref_mem[w], o.dat, o.be);
    end
    ref_last_acc = 1'b0;
    repeat (LAT + 4) step();
  endtask

  task automatic fairness();
    op_t wops[4];
    op_t aops[4];
`ifdef MPRJRAM_ARB_STATS_EN
    logic [15:0] w0, a0, s0;
    w0 = stat_wb_cnt; a0 = stat_acc_cnt; s0 = stat_stall_cnt;
`endif
    for (int i = 0; i < 4; i++) begin wops[i] = rand_wb(); aops[i] = rand_acc(); end
    // Strict alternation: each pair starts with the requester not served last.
    for (int i = 0; i < 4; i++) begin
      if (ref_last_acc) begin void'(model_wb(wops[i], -1)); void'(model_acc(aops[i], -1)); end
      else begin void'(model_acc(aops[i], -1)); void'(model_wb(wops[i], -1)); end
    end
    fork
      begin for (int i = 0; i < 4; i++) wb_drive(wops[i]); end
      begin for (int j = 0; j < 4; j++) acc_drive(aops[j]); end
    join
    step();
`ifdef MPRJRAM_ARB_STATS_EN
    tests++;
    if (16'(stat_wb_cnt - w0) != 16'd4 || 16'(stat_acc_cnt - a0) != 16'd4 ||
        stat_stall_cnt == s0) begin
      fails++;
      $display("FAIL stats: wb+%0d acc+%0d stall+%0d required 4 4 >0",
               16'(stat_wb_cnt - w0), 16'(stat_acc_cnt - a0), 16'(stat_stall_cnt - s0));
    end
`endif
  endtask

  initial begin
    op_t nop;
    nop = mk(1'b0, 4'd0, 32'd0, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'd0;
    wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
    acc_req = 1'b0; acc_we = 4'd0; acc_addr = '0; acc_wdata = 32'd0;

    // Preload BRAM and shadow memory while in reset.
    step();
    for (int i = 0; i < 1024; i++) begin
      pre_addr = 10'(i);
      pre_data = (i == 4) ? 32'h0000_003E : (i == 5) ? 32'h1122_3344 : $urandom;
      ref_mem[i] = pre_data;
      pre_we = 1'b1;
      step();
    end
    pre_we = 1'b0;
    check_zero("reset_state");
    rst_n = 1'b1;
    ref_last_acc = 1'b1;

    // Both request in the first cycle after reset: WB wins the first tie.
    run_batch(1'b1, mk(1'b0, 4'd0, 32'h3800_0010, 32'd0), 1'b1, mk(1'b0, 4'd0, 32'd7, 32'd0));
    // Single WB read of word 4, then partial write and readback of word 5.
    run_batch(1'b1, mk(1'b0, 4'd0, 32'h3800_0010, 32'd0), 1'b0, nop);
    run_batch(1'b1, mk(1'b1, 4'b0011, 32'h3800_0014, 32'hAABB_CCDD), 1'b0, nop);
    run_batch(1'b1, mk(1'b0, 4'd0, 32'h3800_0014, 32'd0), 1'b0, nop);

    fairness();

    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = $urandom_range(1, 3);
      run_batch(mode[0], rand_wb(), mode[1], rand_acc());
    end

    // Aliasing: top word written by ACC, byte address 0x1000 wraps to word 0.
    run_batch(1'b0, nop, 1'b1, mk(1'b0, 4'hF, 32'h3FF, 32'hDEAD_BEEF));
    run_batch(1'b1, mk(1'b1, 4'hF, 32'h3800_1000, 32'h0BAD_F00D), 1'b0, nop);
    run_batch(1'b1, mk(1'b0, 4'd0, 32'h3800_0000, 32'd0), 1'b0, nop);
    run_batch(1'b0, nop, 1'b1, mk(1'b0, 4'd0, 32'h3FF, 32'd0));

    // Abandoned WB cycles: access completes in BRAM, no ack is issued.
    wb_abort(mk(1'b1, 4'hF, 32'h3800_0030, 32'h5555_AAAA), 1);
    wb_abort(mk(1'b0, 4'd0, 32'h3800_0034, 32'd0), 2);
    run_batch(1'b1, mk(1'b0, 4'd0, 32'h3800_0030, 32'd0), 1'b0, nop);

    // Reset asserted mid-read (lat_cnt=5), then a fresh read.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'd0;
    wbs_adr_i = 32'h3800_0024;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_read");
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (LAT + 3) step();
    rst_n = 1'b1;
    ref_last_acc = 1'b1;
    step();
    run_batch(1'b1, mk(1'b0, 4'd0, 32'h3800_0024, 32'd0), 1'b1, mk(1'b0, 4'd0, 32'd4, 32'd0));

    repeat (LAT + 4) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected events left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
